// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit.
// Owns the architectural HI/LO registers and runs mult/multu/div/divu as a
// fixed-latency multi-cycle operation. The result is computed when the op is
// accepted, held in a temporary register, and committed to HI/LO on the last
// busy edge. Start/Busy feed the hazard unit; MDUOut feeds the EX result mux.
//
// Handshake: an MDU op (1-4) is accepted on the rising edge where Start=1,
// i.e. while the unit is idle. Busy then stays high for exactly MULT_CYCLES
// or DIV_CYCLES cycles. Ops arriving while Busy=1 are dropped without effect.
// HI/LO writes are visible in the first cycle with Busy=0, which is also
// the first cycle in which a new op can be accepted.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut,
  output logic        dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [31:0]     r_tmp_hi;
  logic [31:0]     r_tmp_lo;
  logic            r_commit;

  logic            w_is_mul;
  logic            w_is_div;
  logic            w_is_start;
  logic            w_div_zero;
  logic            w_last;
  logic [63:0]     w_prod_s;
  logic [63:0]     w_prod_u;
  logic [31:0]     w_divisor;
  logic [31:0]     w_quot_u;
  logic [31:0]     w_rem_u;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]     w_res_hi;
  logic [31:0]     w_res_lo;

  assign w_is_mul   = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign w_is_div   = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign w_is_start = w_is_mul || w_is_div;
  assign w_div_zero = w_is_div && (B == 32'd0);
  assign w_last     = (r_cnt == CW'(1));

  // Signed product via sign-extended 64-bit multiply: the low 64 bits of the
  // product are the exact two's-complement result.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // A zero divisor never commits, so substitute 1 to keep the divider free of X.
  assign w_divisor = (B == 32'd0) ? 32'd1 : B;
  assign w_quot_u  = A / w_divisor;
  assign w_rem_u   = A % w_divisor;
  assign w_quot_s  = $signed(A) / $signed(w_divisor);
  assign w_rem_s   = $signed(A) % $signed(w_divisor);

  // Select the full HI/LO result for the op being accepted.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (MDUOp)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV:   begin w_res_hi = w_rem_s;         w_res_lo = w_quot_s;       end
      OP_DIVU:  begin w_res_hi = w_rem_u;         w_res_lo = w_quot_u;       end
      default:  begin w_res_hi = 32'd0;           w_res_lo = 32'd0;          end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: accept in IDLE, return to IDLE on the final countdown edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_is_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture result and latency on accept, count down, commit, mthi/mtlo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_tmp_hi <= 32'd0;
      r_tmp_lo <= 32'd0;
      r_commit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_start) begin
            r_tmp_hi <= w_res_hi;
            r_tmp_lo <= w_res_lo;
            r_cnt    <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_commit <= !w_div_zero;
          end else if (MDUOp == OP_MTHI) begin
            r_hi <= A;
          end else if (MDUOp == OP_MTLO) begin
            r_lo <= A;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_last && r_commit) begin
            r_hi <= r_tmp_hi;
            r_lo <= r_tmp_lo;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Combinational read port for mfhi/mflo.
  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == OP_MFHI)      MDUOut = r_hi;
    else if (MDUOp == OP_MFLO) MDUOut = r_lo;
  end

  assign Start     = w_is_start && (r_state == S_IDLE);
  assign Busy      = (r_state == S_BUSY);
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ex_mdu.sv
// Testbench for ex_mdu: scenario tasks driving ops, expected HI/LO pushed to
// a queue on issue and popped when Busy falls.
module tb_ex_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;
  logic        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut),
    .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: {hi, lo} after the op, given the current HI/LO.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    int sa;
    int sb;
    longint sp;
    longint unsigned up;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    model = {hi, lo};
    case (op)
      4'd1: begin sp = longint'(sa) * longint'(sb); model = sp; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; model = up; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; model = {r, q}; end
      4'd4: if (b != 0) begin q = a / b; r = a % b; model = {r, q}; end
      default: model = {hi, lo};
    endcase
  endfunction

  // Issue one long op from a negedge, count busy cycles, check commit.
  // Returns at a negedge with Busy=0, so a following call is back-to-back.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n);
    logic [63:0] e;
    int cnt;
    exp_q.push_back(model(op, a, b, m_hi, m_lo));
    MDUOp = op; A = a; B = b;
    #1;
    n_cmp++;
    if (Start !== 1'b1) begin
      n_bad++; $display("FAIL %s start: got %b want 1", name, Start);
    end
    @(posedge clk); #1;
    MDUOp = 4'd0;
    n_cmp++;
    if (Start !== 1'b0) begin
      n_bad++; $display("FAIL %s start_pulse: got %b want 0", name, Start);
    end
    cnt = 0;
    for (int g = 0; g < 64; g++) begin
      @(negedge clk);
      if (!Busy) break;
      cnt++;
    end
    n_cmp++;
    if (cnt != n) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, cnt, n);
    end
    e = exp_q.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    n_cmp++;
    if (HI !== e[63:32] || LO !== e[31:0]) begin
      n_bad++; $display("FAIL %s hilo: got %h/%h want %h/%h", name, HI, LO, e[63:32], e[31:0]);
    end
  endtask

  // mthi/mtlo from a negedge; returns at the next negedge.
  task automatic move_to(input string name, input logic [3:0] op, input logic [31:0] a);
    MDUOp = op; A = a;
    #1;
    n_cmp++;
    if (Start !== 1'b0) begin
      n_bad++; $display("FAIL %s start: got %b want 0", name, Start);
    end
    @(posedge clk); #1;
    MDUOp = 4'd0;
    if (op == 4'd7) m_hi = a;
    else            m_lo = a;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      n_bad++; $display("FAIL %s: got busy=%b %h/%h want busy=0 %h/%h", name, Busy, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
    #2;
    n_cmp++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || Start !== 1'b0 ||
        MDUOut !== 32'd0 || dbg_state !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: got hi=%h lo=%h busy=%b start=%b out=%h st=%b want all 0",
                        HI, LO, Busy, Start, MDUOut, dbg_state);
    end
    MDUOp = 4'd1; #1;
    n_cmp++;
    if (Start !== 1'b1) begin
      n_bad++; $display("FAIL reset_start_comb: got %b want 1", Start);
    end
    MDUOp = 4'd0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    @(negedge clk);
    run_op("mult_signed", 4'd1, 32'hFFFFFFFF, 32'h2, MC);
    n_cmp++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
      n_bad++; $display("FAIL mult_plan: got %h/%h want ffffffff/fffffffe", HI, LO);
    end
    @(negedge clk);
    run_op("mult_unsigned", 4'd2, 32'hFFFFFFFF, 32'h2, MC);
    n_cmp++;
    if (HI !== 32'h1 || LO !== 32'hFFFFFFFE) begin
      n_bad++; $display("FAIL multu_plan: got %h/%h want 00000001/fffffffe", HI, LO);
    end
  endtask

  task automatic test_div();
    @(negedge clk);
    run_op("div_signed", 4'd3, 32'hFFFFFFF9, 32'h2, DC);
    n_cmp++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      n_bad++; $display("FAIL div_plan: got %h/%h want ffffffff/fffffffd", HI, LO);
    end
    @(negedge clk);
    run_op("div_unsigned", 4'd4, 32'd7, 32'd2, DC);
    n_cmp++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      n_bad++; $display("FAIL divu_plan: got %h/%h want 00000001/00000003", HI, LO);
    end
    @(negedge clk);
    run_op("div_pos_neg", 4'd3, 32'd7, 32'hFFFFFFFE, DC);
  endtask

  task automatic test_div_zero();
    @(negedge clk);
    move_to("mthi", 4'd7, 32'h11);
    move_to("mtlo", 4'd8, 32'h22);
    run_op("div_zero", 4'd3, 32'd1234, 32'd0, DC);
    run_op("divu_zero", 4'd4, 32'd99, 32'd0, DC);
    n_cmp++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      n_bad++; $display("FAIL div0_keep: got %h/%h want 00000011/00000022", HI, LO);
    end
    MDUOp = 4'd5; #1;
    n_cmp++;
    if (MDUOut !== 32'h11) begin
      n_bad++; $display("FAIL mfhi: got %h want 00000011", MDUOut);
    end
    MDUOp = 4'd6; #1;
    n_cmp++;
    if (MDUOut !== 32'h22) begin
      n_bad++; $display("FAIL mflo: got %h want 00000022", MDUOut);
    end
    MDUOp = 4'd12; #1;
    n_cmp++;
    if (MDUOut !== 32'd0 || Start !== 1'b0) begin
      n_bad++; $display("FAIL op_illegal: got out=%h start=%b want 0/0", MDUOut, Start);
    end
    @(posedge clk); #1;
    MDUOp = 4'd0;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin
      n_bad++; $display("FAIL op_illegal_noeffect: got busy=%b %h/%h want 0 11/22", Busy, HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_op("b2b_first", 4'd1, 32'd3, 32'd4, MC);
    MDUOp = 4'd6; #1;
    n_cmp++;
    if (MDUOut !== 32'd12) begin
      n_bad++; $display("FAIL b2b_mflo: got %h want 0000000c", MDUOut);
    end
    run_op("b2b_second", 4'd4, 32'd100, 32'd7, DC);
    run_op("b2b_third", 4'd2, 32'h80000000, 32'h80000000, MC);
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      if (a == 32'h80000000) a = 32'h1;
      if (i == 3) b = 32'd0;
      @(negedge clk);
      run_op("random", op, a, b, (op <= 4'd2) ? MC : DC);
    end
  endtask

  task automatic test_busy_reset();
    @(negedge clk);
    move_to("pre_mthi", 4'd7, 32'hAA);
    MDUOp = 4'd1; A = 32'd3; B = 32'd4;
    #1;
    n_cmp++;
    if (Start !== 1'b1) begin
      n_bad++; $display("FAIL br_start: got %b want 1", Start);
    end
    @(posedge clk); #1;
    MDUOp = 4'd0;
    @(negedge clk);
    MDUOp = 4'd8; A = 32'h55;
    #1;
    n_cmp++;
    if (Busy !== 1'b1 || Start !== 1'b0) begin
      n_bad++; $display("FAIL br_ignore_start: got busy=%b start=%b want 1/0", Busy, Start);
    end
    @(posedge clk); #1;
    MDUOp = 4'd0;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 1'b1 || LO !== m_lo || HI !== 32'hAA) begin
      n_bad++; $display("FAIL br_ignored: got busy=%b %h/%h want 1 000000aa/%h", Busy, HI, LO, m_lo);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_bad++; $display("FAIL br_async_reset: got busy=%b %h/%h want 0 0/0", Busy, HI, LO);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_bad++; $display("FAIL br_no_commit: got busy=%b %h/%h want 0 0/0", Busy, HI, LO);
    end
    run_op("br_after", 4'd1, 32'd6, 32'hFFFFFFF9, MC);
    n_cmp++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFD6) begin
      n_bad++; $display("FAIL br_after_value: got %h/%h want ffffffff/ffffffd6", HI, LO);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_busy_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage. Sits directly downstream of the ID/EX pipeline register.
- Consumes the 4-bit MDUOp decoded from Instr_E, plus rsData_E and rtData_E.
- Owns the architectural HI/LO registers and runs multi-cycle mult/div.
- Reports Start/Busy to the hazard unit, which stalls the next MDU instruction in D. Supplies mfhi/mflo data to the EX result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- A  input  32  rs operand (rsData_E after forwarding).
- B  input  32  rt operand (rtData_E after forwarding).
- Start  output  1  combinational; 1 when MDUOp is 1-4 and the unit is idle.
- Busy  output  1  registered; 1 while an operation is in flight.
- HI  output  32  committed HI register.
- LO  output  32  committed LO register.
- MDUOut  output  32  combinational; HI if MDUOp=5, LO if MDUOp=6, else 0.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, counter=0, temporary results cleared, state IDLE. Start and MDUOut then follow their inputs combinationally.
- Reset asserted mid-operation aborts it; HI/LO are not committed.
- States are IDLE and BUSY. Busy = (state==BUSY).
- IDLE, MDUOp in 1-4, rising edge:
  - compute the full result from A and B into temporary hi/lo;
  - load counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4);
  - go to BUSY.
- BUSY, each edge: decrement the counter. On the edge where the counter equals 1, write temporary hi/lo into HI/LO and return to IDLE.
- Timing: Busy is high for exactly N cycles after the cycle in which Start=1. New HI/LO are visible in the first cycle with Busy=0.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; {HI,LO} = product.
  - multu: unsigned 32x32 -> 64-bit product; {HI,LO} = product.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B=0, op 3 or 4): the unit still goes Busy for DIV_CYCLES, but HI/LO keep their previous values at commit.
- mthi/mtlo in IDLE: on the rising edge, HI<=A (mthi) or LO<=A (mtlo). No Busy.
- mfhi/mflo: pure combinational reads of committed HI/LO. No state change.
- Any MDUOp 1-8 arriving while Busy=1 is ignored: no state change and Start=0. The hazard unit guarantees this never happens; the unit must still be robust to it.
- MDUOp=0 (including nops inserted by a stall or flush): no effect.
- Back-to-back: Busy falls and a new op is accepted in the same cycle. The second op sees the committed HI/LO of the first.

Test Plan:
- Signed mult: MDUOp=1, A=0xFFFFFFFF, B=0x00000002 -> Start=1 for 1 cycle, Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Unsigned mult: MDUOp=2, A=0xFFFFFFFF, B=0x00000002 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed div: MDUOp=3, A=0xFFFFFFF9 (-7), B=2 -> Busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned div: MDUOp=4, A=7, B=2 -> LO=3, HI=1.
- Divide by zero: preload with mthi A=0x11, mtlo A=0x22, then div by B=0 -> Busy for 10 cycles, HI/LO remain 0x11/0x22. MDUOp=5 then gives MDUOut=0x11.
- Reset and illegal-while-busy: start mult 3x4, drive mtlo A=0x55 during Busy -> ignored. Pull reset low in busy cycle 2 -> HI=LO=0 and Busy=0 immediately (asynchronous). After release, a new mult is accepted normally.
